// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one shared full adder processes WIDTH bits LSB first,
// one bit per clock, under a three-state IDLE/RUN/DONE controller.

module full_adder_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder_dataflow u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // NOTE: every register here is written with <= so all updates in this block
    // see the pre-edge values, which is what the shift/carry chain relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and force the carry-in.
                        sa    <= A;
                        sb    <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // On the last bit, carry still holds the carry into the MSB stage.
                        Sum   <= {fa_s, res[WIDTH-1:1]};
                        Cout  <= fa_co;
                        Ovf   <= carry ^ fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): cycle-accurate busy/done timing,
// arithmetic results, reset abort, ignored starts and start held through reset.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sub   (Sub),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and check busy/done every cycle, then the result and its hold.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        start = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
        tick();
        start = 1'b0; A = ~a; B = 8'h5A; Cin = ~cin; Sub = ~sub;
        for (int c = 0; c < WIDTH; c++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s run%0d: busy=%b done=%b, want busy=1 done=0", name, c, busy, done);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || Sum !== exp_sum || Cout !== exp_cout || Ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s result: done=%b busy=%b Sum=%h Cout=%b Ovf=%b, want 1 0 %h %b %b",
                     name, done, busy, Sum, Cout, Ovf, exp_sum, exp_cout, exp_ovf);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || Sum !== exp_sum || Cout !== exp_cout || Ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s hold: done=%b busy=%b Sum=%h Cout=%b Ovf=%b, want 0 0 %h %b %b",
                     name, done, busy, Sum, Cout, Ovf, exp_sum, exp_cout, exp_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1; Sub = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b Sum=%h Cout=%b Ovf=%b, want all 0", busy, done, Sum, Cout, Ovf);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b done=%b Sum=%h, want 0 0 00", busy, done, Sum);
        end
    endtask

    task automatic test_add();
        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_ff_00_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_12_34_cin", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_sub();
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_10_03_cin0", 8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_reset_abort();
        start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b0; Sub = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: busy=%b done=%b Sum=%h Cout=%b Ovf=%b, want all 0", busy, done, Sum, Cout, Ovf);
        end
        rst = 1'b0;
        for (int c = 0; c < WIDTH + 2; c++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet%0d: busy=%b done=%b, want 0 0", c, busy, done);
            end
        end
        run_op("after_abort_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b0; Sub = 1'b0;
        tick();
        for (int c = 0; c < WIDTH; c++) begin
            if (c == 2) begin
                start = 1'b1; A = 8'h11; B = 8'h22;
            end else begin
                start = 1'b0;
            end
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b run%0d: busy=%b done=%b, want busy=1 done=0", c, busy, done);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || Sum !== 8'h02 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b result: done=%b Sum=%h Cout=%b Ovf=%b, want 1 02 0 0", done, Sum, Cout, Ovf);
        end
        start = 1'b1; A = 8'h11; B = 8'h22;
        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b after_done: done=%b busy=%b, want 0 0", done, busy);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h02) begin
            miscompares++;
            $display("FAIL b2b ignored: busy=%b done=%b Sum=%h, want 0 0 02", busy, done, Sum);
        end
    endtask

    task automatic test_start_through_reset();
        rst = 1'b1; start = 1'b1; A = 8'h03; B = 8'h04; Cin = 1'b0; Sub = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_priority: busy=%b, want 0", busy);
        end
        rst = 1'b0;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_at_release: busy=%b, want 1", busy);
        end
        for (int c = 1; c < WIDTH; c++) tick();
        tick();
        vectors++;
        if (done !== 1'b1 || Sum !== 8'h07 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL release_result: done=%b Sum=%h Cout=%b Ovf=%b, want 1 07 0 0", done, Sum, Cout, Ovf);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_reset_abort();
        test_back_to_back();
        test_start_through_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
